// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - duty-cycle ramp sequencer for the PWM generator
// Optional abort input and behaviour enabled by defining PWM_RAMP_ABORT_EN.
module pwm_duty_ramp_ctrl #(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_target,
    input  logic [WIDTH-1:0]  cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic [WIDTH-1:0]  duty_cycle,
    output logic              period_tick,
    output logic              busy,
    output logic              done
`ifdef PWM_RAMP_ABORT_EN
    ,
    input  logic              abort
`endif
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    cnt_q;
    logic [WIDTH-1:0]    duty_q, duty_d;
    logic [WIDTH-1:0]    target_q, step_q;
    logic [HOLD_W-1:0]   hold_q, hold_cnt_q, hold_cnt_d;
    logic                done_q, done_d;
    logic                load;
    logic                accept;
    logic                abort_hit;
    logic                up;
    logic [WIDTH-1:0]    diff;
    logic [WIDTH-1:0]    step_val;
    logic [WIDTH-1:0]    step_in;

`ifdef PWM_RAMP_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign busy        = (state_q == RAMP);
    assign period_tick = &cnt_q;
    assign duty_cycle  = duty_q;
    assign done        = done_q;
    assign accept      = cmd_valid && cmd_ready;
    assign step_in     = (cmd_step == '0) ? WIDTH'(1) : cmd_step;

    // Clamp to the target whenever the remaining distance fits in one step,
    // so the arithmetic can never wrap.
    assign up       = target_q > duty_q;
    assign diff     = up ? (target_q - duty_q) : (duty_q - target_q);
    assign step_val = (diff <= step_q) ? target_q
                    : (up ? (duty_q + step_q) : (duty_q - step_q));

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    hold_cnt_d = cmd_hold;
                    if (cmd_target == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (abort_hit) begin
                    state_d = IDLE;
                end else if (period_tick) begin
                    if (hold_cnt_q == '0) begin
                        duty_d     = step_val;
                        hold_cnt_d = hold_q;
                        if (step_val == target_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            target_q   <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_q + WIDTH'(1);
            duty_q     <= duty_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
            if (load) begin
                target_q <= cmd_target;
                step_q   <= step_in;
                hold_q   <= cmd_hold;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb/tb_pwm_duty_ramp_ctrl.sv - directed self-checking bench for pwm_duty_ramp_ctrl
module tb_pwm_duty_ramp_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_hold;
    logic [7:0] duty_cycle;
    logic       period_tick;
    logic       busy;
    logic       done;
`ifdef PWM_RAMP_ABORT_EN
    logic       abort;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp_ctrl #(.WIDTH(8), .HOLD_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .cmd_hold    (cmd_hold),
        .duty_cycle  (duty_cycle),
        .period_tick (period_tick),
        .busy        (busy),
        .done        (done)
`ifdef PWM_RAMP_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    task automatic wait_tick(output bit ok);
        int n = 0;
        while (!period_tick && n < 600) begin
            @(negedge clk);
            n++;
        end
        ok = period_tick;
    endtask

    task automatic send_cmd(input logic [7:0] t, input logic [7:0] s, input logic [7:0] h);
        cmd_target = t;
        cmd_step   = s;
        cmd_hold   = h;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_target = 8'hEE;
        cmd_step   = 8'h77;
        cmd_hold   = 8'h33;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
        checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL rst_duty got=%0d exp=0", duty_cycle); end
        checks++; if ({busy, done, period_tick} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {busy, done, period_tick}); end
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", cmd_ready); end
        for (int c = 1; c <= 511; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (duty_cycle !== 8'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL cyc1 duty=%0d ready=%b exp 0/1", duty_cycle, cmd_ready); end
            end
            if (c == 254 || c == 256) begin
                checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL tick_c%0d got=%b exp=0", c, period_tick); end
            end
            if (c == 255 || c == 511) begin
                checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL tick_c%0d got=%b exp=1", c, period_tick); end
            end
        end
    endtask

    // Entered on a tick cycle: that tick must not count toward the ramp.
    task automatic test_ramp_up;
        logic [7:0] exp_v [4] = '{8'd25, 8'd50, 8'd75, 8'd100};
        logic [7:0] prev = 8'd0;
        bit ok;
        send_cmd(8'd100, 8'd25, 8'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy got=%b exp=1", busy); end
        for (int k = 0; k < 4; k++) begin
            wait_tick(ok);
            checks++; if (!ok || duty_cycle !== prev) begin errors++; $display("FAIL up_pre%0d tick=%b duty=%0d exp %0d", k, ok, duty_cycle, prev); end
            @(negedge clk);
            checks++; if (duty_cycle !== exp_v[k]) begin errors++; $display("FAIL up_duty%0d got=%0d exp=%0d", k, duty_cycle, exp_v[k]); end
            checks++; if (done !== (k == 3)) begin errors++; $display("FAIL up_done%0d got=%b exp=%b", k, done, k == 3); end
            prev = exp_v[k];
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL up_ready_on_done got=%b exp=1", cmd_ready); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL up_after got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_ramp_down_hold;
        logic [7:0] exp_v [4] = '{8'd70, 8'd40, 8'd10, 8'd0};
        logic [7:0] prev = 8'd100;
        bit ok;
        send_cmd(8'd0, 8'd30, 8'd1);
        for (int k = 0; k < 4; k++) begin
            wait_tick(ok);
            @(negedge clk);
            checks++; if (!ok || duty_cycle !== prev) begin errors++; $display("FAIL dn_hold%0d tick=%b duty=%0d exp %0d", k, ok, duty_cycle, prev); end
            wait_tick(ok);
            @(negedge clk);
            checks++; if (!ok || duty_cycle !== exp_v[k]) begin errors++; $display("FAIL dn_duty%0d tick=%b got=%0d exp=%0d", k, ok, duty_cycle, exp_v[k]); end
            checks++; if (done !== (k == 3)) begin errors++; $display("FAIL dn_done%0d got=%b exp=%b", k, done, k == 3); end
            if (k == 0) begin
                cmd_target = 8'd200;
                cmd_step   = 8'd50;
                cmd_valid  = 1'b1;
                #1;
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL dn_ready_in_ramp got=%b exp=0", cmd_ready); end
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            prev = exp_v[k];
        end
        @(negedge clk);
        checks++; if ({busy, done, duty_cycle} !== {2'b00, 8'd0}) begin errors++; $display("FAIL dn_after busy=%b done=%b duty=%0d exp 0/0/0", busy, done, duty_cycle); end
    endtask

    task automatic test_step_zero_reset;
        bit ok;
        send_cmd(8'd3, 8'd0, 8'd0);
        for (int k = 1; k <= 2; k++) begin
            wait_tick(ok);
            @(negedge clk);
            checks++; if (!ok || duty_cycle !== 8'(k)) begin errors++; $display("FAIL sz_duty%0d got=%0d exp=%0d", k, duty_cycle, k); end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, cmd_ready, duty_cycle} !== {3'b000, 8'd0}) begin errors++; $display("FAIL sz_reset busy=%b done=%b ready=%b duty=%0d exp 0/0/0/0", busy, done, cmd_ready, duty_cycle); end
        reset = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if ({busy, done, cmd_ready, duty_cycle} !== {3'b001, 8'd0}) begin errors++; $display("FAIL sz_post%0d busy=%b done=%b ready=%b duty=%0d exp 0/0/1/0", c, busy, done, cmd_ready, duty_cycle); end
            @(negedge clk);
        end
    endtask

    task automatic test_clamp_same_target;
        logic [7:0] exp_v [3] = '{8'd4, 8'd8, 8'd10};
        bit ok;
        send_cmd(8'd10, 8'd4, 8'd0);
        for (int k = 0; k < 3; k++) begin
            wait_tick(ok);
            @(negedge clk);
            checks++; if (!ok || duty_cycle !== exp_v[k]) begin errors++; $display("FAIL cl_duty%0d got=%0d exp=%0d", k, duty_cycle, exp_v[k]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cl_done got=%b exp=1", done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cl_done_width got=%b exp=0", done); end
        send_cmd(8'd10, 8'd9, 8'd5);
        checks++; if ({done, busy, duty_cycle} !== {2'b10, 8'd10}) begin errors++; $display("FAIL same_tgt done=%b busy=%b duty=%0d exp 1/0/10", done, busy, duty_cycle); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL same_tgt_width got=%b exp=0", done); end
    endtask

`ifdef PWM_RAMP_ABORT_EN
    task automatic test_abort;
        bit ok;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, cmd_ready, duty_cycle} !== {2'b01, 8'd10}) begin errors++; $display("FAIL ab_idle busy=%b ready=%b duty=%0d exp 0/1/10", busy, cmd_ready, duty_cycle); end
        send_cmd(8'd210, 8'd50, 8'd0);
        wait_tick(ok);
        @(negedge clk);
        checks++; if (!ok || duty_cycle !== 8'd60) begin errors++; $display("FAIL ab_duty0 got=%0d exp=60", duty_cycle); end
        wait_tick(ok);
        @(negedge clk);
        checks++; if (!ok || duty_cycle !== 8'd110) begin errors++; $display("FAIL ab_duty1 got=%0d exp=110", duty_cycle); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, done, cmd_ready, duty_cycle} !== {3'b001, 8'd110}) begin errors++; $display("FAIL ab_stop busy=%b done=%b ready=%b duty=%0d exp 0/0/1/110", busy, done, cmd_ready, duty_cycle); end
        wait_tick(ok);
        @(negedge clk);
        checks++; if (duty_cycle !== 8'd110) begin errors++; $display("FAIL ab_frozen got=%0d exp=110", duty_cycle); end
        send_cmd(8'd150, 8'd10, 8'd0);
        wait_tick(ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, done, duty_cycle} !== {2'b00, 8'd110}) begin errors++; $display("FAIL ab_same_edge busy=%b done=%b duty=%0d exp 0/0/110", busy, done, duty_cycle); end
        send_cmd(8'd120, 8'd10, 8'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_reaccept got=%b exp=1", busy); end
        wait_tick(ok);
        @(negedge clk);
        checks++; if (!ok || {done, duty_cycle} !== {1'b1, 8'd120}) begin errors++; $display("FAIL ab_final done=%b duty=%0d exp 1/120", done, duty_cycle); end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 8'd0;
        cmd_step   = 8'd0;
        cmd_hold   = 8'd0;
`ifdef PWM_RAMP_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_ramp_up();
        test_ramp_down_hold();
        test_step_zero_reset();
        test_clamp_same_target();
`ifdef PWM_RAMP_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
